// File: rtl/pulse_arb_pkg.sv
// Shared types and default sizing for the pulse arbiter.
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int DEF_N_BTN = 4;
  localparam int DEF_GAP   = 3;

endpackage

// File: rtl/pulse_arbiter_btn_edge_det.sv
// Per-channel press detector: rising-edge strobe plus the pending request flag
// and the one-cycle overrun flag for a press that arrives while still pending.
module btn_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  input  logic clr_i,
  output logic pending_o,
  output logic overrun_o
);

  logic prev_q;
  logic rise;

  // prev_q resets high so a button held through reset release is not a press
  assign rise = btn_i & ~prev_q;

  // Track the previous level, then update pending (set beats clear) and overrun
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q    <= 1'b1;
      pending_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      prev_q    <= btn_i;
      overrun_o <= rise & pending_o & ~clr_i;
      if (rise) begin
        pending_o <= 1'b1;
      end else if (clr_i) begin
        pending_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter that turns button presses into single-cycle tagged pulses
// on one shared channel, with a fixed idle gap after every pulse.
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter  int N_BTN = DEF_N_BTN,
  parameter  int GAP   = DEF_GAP,
  localparam int ID_W  = $clog2(N_BTN)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_BTN-1:0] button_i,
  input  logic             enable_i,
  output logic             pulse_o,
  output logic [ID_W-1:0]  pulse_id_o,
  output logic [N_BTN-1:0] pending_o,
  output logic [N_BTN-1:0] overrun_o
);

  // The parameter GAP shadows the enum literal, so the state is named via the package
  localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             grant_fire;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overrun;
  logic [N_BTN-1:0] clr_vec;
  logic [CNT_W-1:0] gap_cnt_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_edge_det u_det (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .btn_i     (button_i[g]),
      .clr_i     (clr_vec[g]),
      .pending_o (pending[g]),
      .overrun_o (overrun[g])
    );
  end

  // Priority scan starting at rr_ptr, wrapping modulo N_BTN
  always_comb begin
    int idx;
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_BTN;
      if (!pick_valid && pending[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && enable_i && pick_valid;

  // One-hot clear of the channel being granted at this edge
  always_comb begin
    clr_vec = '0;
    if (grant_fire) begin
      clr_vec[pick_id] = 1'b1;
    end
  end

  // Next-state logic: IDLE -> GRANT -> GAP (skipped when GAP is zero) -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = (GAP > 0) ? pulse_arb_pkg::GAP : IDLE;
      end
      pulse_arb_pkg::GAP: begin
        if (gap_cnt_q == CNT_W'(GAP - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, granted id, round-robin pointer and gap counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        id_q     <= pick_id;
        rr_ptr_q <= (pick_id == ID_W'(N_BTN - 1)) ? '0 : pick_id + ID_W'(1);
      end
      if (state_q == GRANT) begin
        gap_cnt_q <= '0;
      end else if (state_q == pulse_arb_pkg::GAP) begin
        gap_cnt_q <= gap_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse_o    = (state_q == GRANT);
  assign pulse_id_o = pulse_o ? id_q : '0;
  assign pending_o  = pending;
  assign overrun_o  = overrun;

endmodule
